// File: rtl/control_unit.sv
// Sequential unsigned shift-add multiplier: one multiplier bit per clock,
// WIDTH iterations per product, result held on p_o until the next one completes.
module control_unit #(
    parameter int WIDTH = 24
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 start_i,
    input  logic [WIDTH-1:0]     x_i,
    input  logic [WIDTH-1:0]     y_i,
    output logic [2*WIDTH-1:0]   p_o
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     a_q, a_d;
    logic [WIDTH:0]       acc_q, acc_d;
    logic [WIDTH-1:0]     q_q, q_d;
    logic [CW-1:0]        count_q, count_d;
    logic [2*WIDTH-1:0]   p_q, p_d;

    logic [WIDTH:0]       sum;
    logic [2*WIDTH:0]     shifted;

    // The accumulator carries one extra bit so the add never loses its carry;
    // the right shift moves that carry back into the product's upper half.
    always_comb begin
        sum     = q_q[0] ? (acc_q + {1'b0, a_q}) : acc_q;
        shifted = {sum, q_q} >> 1;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            a_q     <= '0;
            acc_q   <= '0;
            q_q     <= '0;
            count_q <= '0;
            p_q     <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            acc_q   <= acc_d;
            q_q     <= q_d;
            count_q <= count_d;
            p_q     <= p_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        acc_d   = acc_q;
        q_d     = q_q;
        count_d = count_q;
        p_d     = p_q;

        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    a_d     = x_i;
                    q_d     = y_i;
                    acc_d   = '0;
                    count_d = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                acc_d   = shifted[2*WIDTH:WIDTH];
                q_d     = shifted[WIDTH-1:0];
                count_d = count_q + CW'(1);
                if (count_q == CW'(WIDTH - 1)) begin
                    p_d     = shifted[2*WIDTH-1:0];
                    state_d = DONE;
                end
            end
            DONE: begin
                // A held start must drop before another product can begin.
                if (!start_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign p_o = p_q;

endmodule

// File: tb/tb_control_unit.sv
// Directed self-checking bench for control_unit with hand-computed products.
module tb_control_unit;

    localparam int W = 24;

    logic             clk_i;
    logic             reset_i;
    logic             start_i;
    logic [W-1:0]     x_i;
    logic [W-1:0]     y_i;
    logic [2*W-1:0]   p_o;

    int testCount = 0;
    int failCount = 0;

    control_unit #(.WIDTH(W)) dut (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .start_i (start_i),
        .x_i     (x_i),
        .y_i     (y_i),
        .p_o     (p_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic applyStimulus(input logic rst, input logic st,
                                 input logic [W-1:0] xv, input logic [W-1:0] yv);
        reset_i = rst;
        start_i = st;
        x_i     = xv;
        y_i     = yv;
    endtask

    task automatic checkOutput(input string tag, input logic [2*W-1:0] expected);
        testCount++;
        assert (p_o === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: p_o=%h expected %h", tag, p_o, expected);
        end
    endtask

    // Start sampled at edge k; old p must survive k+23, new p appears at k+24.
    task automatic runOp(input string tag, input logic [W-1:0] xv, input logic [W-1:0] yv,
                         input logic [2*W-1:0] prevP, input logic [2*W-1:0] expP);
        applyStimulus(1'b0, 1'b1, xv, yv);
        step(1);
        step(11);
        checkOutput({tag, "_mid"}, prevP);
        step(12);
        checkOutput({tag, "_hold"}, prevP);
        step(1);
        checkOutput(tag, expP);
    endtask

    initial begin
        applyStimulus(1'b1, 1'b0, '0, '0);
        step(2);
        checkOutput("reset", 48'h0);

        runOp("basic", 24'd110, 24'd29, 48'h0, 48'd3190);
        applyStimulus(1'b0, 1'b1, 24'd5, 24'd5);
        step(30);
        checkOutput("no_retrigger", 48'd3190);

        applyStimulus(1'b0, 1'b0, 24'd5, 24'd5);
        step(1);
        runOp("max", 24'hFFFFFF, 24'hFFFFFF, 48'd3190, 48'hFFFFFE000001);

        applyStimulus(1'b0, 1'b0, '0, '0);
        step(1);
        runOp("zero", 24'h0, 24'hABCDEF, 48'hFFFFFE000001, 48'h0);

        applyStimulus(1'b0, 1'b0, '0, '0);
        step(1);
        runOp("identity", 24'h1, 24'hABCDEF, 48'h0, 48'h0000_00AB_CDEF);

        // Operands and start change five edges into CALC; latched values win.
        applyStimulus(1'b0, 1'b0, '0, '0);
        step(1);
        applyStimulus(1'b0, 1'b1, 24'd1000, 24'd1000);
        step(1);
        step(5);
        applyStimulus(1'b0, 1'b0, 24'd7, 24'd9);
        step(18);
        checkOutput("midchange_hold", 48'h0000_00AB_CDEF);
        step(1);
        checkOutput("midchange", 48'd1000000);
        step(10);
        checkOutput("midchange_idle", 48'd1000000);

        // Reset ten edges into CALC with start held high.
        applyStimulus(1'b0, 1'b1, 24'd110, 24'd29);
        step(1);
        step(9);
        applyStimulus(1'b1, 1'b1, 24'd110, 24'd29);
        step(1);
        checkOutput("midreset", 48'h0);
        runOp("after_reset", 24'd110, 24'd29, 48'h0, 48'd3190);

        applyStimulus(1'b1, 1'b1, 24'd110, 24'd29);
        step(1);
        checkOutput("reset_held_first", 48'h0);
        step(40);
        checkOutput("reset_held", 48'h0);

        applyStimulus(1'b0, 1'b0, 24'd110, 24'd29);
        step(30);
        checkOutput("idle_no_start", 48'h0);

        runOp("pow2", 24'h800000, 24'h800000, 48'h0, 48'h4000_0000_0000);
        applyStimulus(1'b0, 1'b0, '0, '0);
        step(1);
        runOp("times2", 24'hFFFFFF, 24'd2, 48'h4000_0000_0000, 48'h0000_01FF_FFFE);
        applyStimulus(1'b0, 1'b0, '0, '0);
        step(1);
        runOp("small", 24'd3, 24'd5, 48'h0000_01FF_FFFE, 48'd15);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
- Sequential unsigned shift-add multiplier with its own controller FSM.
- Serves as the mantissa multiplier of the floating-point multiply path, taking two WIDTH-bit significands (24 by default) and producing the full 2*WIDTH-bit product.
- Processes one multiplier bit per clock.
- Holds the result on p until the next operation completes.

Parameters:
- WIDTH, 24, operand width in bits. Product width is 2*WIDTH. Iteration count is WIDTH.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  level request to begin a multiplication.
- x  input  WIDTH  multiplicand, unsigned.
- y  input  WIDTH  multiplier, unsigned.
- p  output  2*WIDTH  registered product, unsigned.

Behaviour:
- Reset: sampled on rising clk edge while reset=1. Takes priority over every other condition.
  - Effect: state<=IDLE, p<=0, internal accumulator/multiplier/counter registers<=0.
  - Reset held high keeps the block in IDLE with p=0 regardless of start.
- States: IDLE, CALC, DONE.
- IDLE:
  - start=0: remain in IDLE, p unchanged.
  - start=1 at edge k: capture A<=x, Q<=y, ACC<=0 (WIDTH+1 bits incl. carry), count<=0, go to CALC.
- CALC, at each of edges k+1..k+WIDTH:
  - If Q[0]=1, sum = ACC + A; otherwise sum = ACC.
  - {ACC,Q} <= {sum,Q} shifted right by one (carry bit enters the MSB).
  - count <= count+1.
  - On the edge where count reaches WIDTH-1 (the WIDTH-th CALC edge, k+WIDTH): load p with the completed product {ACC,Q} after that shift, and go to DONE.
- Latency: start sampled at edge k gives the new p at edge k+WIDTH (k+24 by default). p keeps its previous value throughout CALC.
- DONE:
  - p held.
  - start=1: stay in DONE. A start level held high does not retrigger.
  - start=0: go to IDLE.
  - A new operation needs start low for at least one edge, then high again.
- During CALC:
  - Changes on x, y and start are ignored; operands are those latched at edge k.
  - start deasserting does not abort.
- Reset mid-CALC: computation aborted, p=0, IDLE on that edge.
- Arithmetic:
  - Purely unsigned; no overflow is possible.
  - p = x*y exactly in 2*WIDTH bits.
  - Max case 0xFFFFFF*0xFFFFFF = 0xFFFFFE000001.
- x/y = 0 are legal. They still take the full WIDTH cycles, giving p=0.
- No combinational path from inputs to p.

Test Plan:
- Basic product:
  - Stimulus: reset=1 for 2 edges then 0; x=110, y=29, raise start.
  - Response: p=0 until 24 edges after start is sampled, then p=3190, held while start stays high, no retrigger.
- Maximum operands:
  - Stimulus: x=y=0xFFFFFF.
  - Response: p=0xFFFFFE000001 after 24 CALC edges.
- Zero and identity:
  - Stimulus: x=0, y=0xABCDEF.
  - Response: p=0.
  - Then: drop start, x=1, y=0xABCDEF, raise start.
  - Response: p=0xABCDEF. Previous p (0) held throughout CALC.
- Operand change mid-CALC:
  - Stimulus: start with x=1000, y=1000; at CALC cycle 5 change x=7, y=9 and drop start.
  - Response: p=1000000, then return to IDLE.
- Reset mid-operation:
  - Stimulus: x=110, y=29, start; assert reset at CALC cycle 10 for 1 edge, with start held at 1.
  - Response: p=0 and IDLE on that edge. If start is still high after reset, a fresh operation starts and p=3190 24 edges later.
- Reset held:
  - Stimulus: reset=1 continuously with start=1, x=110, y=29.
  - Response: p remains 0 forever.
